// File: rtl/ccl_pkg.sv
// ccl_pkg -- shared constants for the connected-component labelling blocks.
// Revision 1.0
`default_nettype none

package ccl_pkg;

   localparam int LABEL_W_DEF     = 8;
   localparam int STACK_DEPTH_DEF = 256;
   localparam int BG_LABEL        = 0;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/merge_stack.sv
// merge_stack -- parametrised LIFO holding pending label equivalences.
// Revision 1.0
`default_nettype none

module merge_stack #(
   parameter int DEPTH  = 256,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       r_count;
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     w_top_idx;
   logic              w_do_push;
   logic              w_do_pop;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign w_top_idx = r_count[AW-1:0] - AW'(1);
   assign top_data  = r_mem[w_top_idx];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_count <= '0;
      end else if (w_do_push && !w_do_pop) begin
         r_count <= r_count + (AW+1)'(1);
      end else if (w_do_pop && !w_do_push) begin
         r_count <= r_count - (AW+1)'(1);
      end
   end

   // Simultaneous push and pop replaces the top entry in place.
   always_ff @(posedge clk) begin
      if (!clear && w_do_push) begin
         if (w_do_pop) begin
            r_mem[w_top_idx] <= push_data;
         end else begin
            r_mem[r_count[AW-1:0]] <= push_data;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/label_merge_unit.sv
// label_merge_unit -- label equivalence table with row-alternating merge stacks.
// Revision 1.0
`default_nettype none

module label_merge_unit
   import ccl_pkg::*;
#(
   parameter int LABEL_W     = LABEL_W_DEF,
   parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               frame_start,
   input  logic               row_sel,
   input  logic               new_label_req,
   input  logic               merge_push,
   input  logic [LABEL_W-1:0] merge_a,
   input  logic [LABEL_W-1:0] merge_b,
   input  logic [LABEL_W-1:0] lookup_addr,
   output logic [LABEL_W-1:0] lookup_data,
   output logic [LABEL_W-1:0] num_labels,
   output logic               busy,
   output logic               stacks_empty,
   output logic               overflow,
   output logic               exhausted
);

   localparam int NUM_ENTRIES = 1 << LABEL_W;
   localparam int PAIR_W      = 2 * LABEL_W;
   localparam logic [LABEL_W-1:0] LAST_LABEL = LABEL_W'(NUM_ENTRIES - 1);
   localparam logic [LABEL_W-1:0] BG         = LABEL_W'(BG_LABEL);

   logic [0:0]         r_state;
   logic [LABEL_W-1:0] r_cnt;
   logic [LABEL_W-1:0] r_tbl [NUM_ENTRIES];
   logic [LABEL_W-1:0] r_rd;
   logic               r_pend;
   logic [LABEL_W-1:0] r_pend_addr;
   logic [LABEL_W-1:0] r_pend_data;

   logic               w_run;
   logic               w_restart;
   logic               w_merge_ok;
   logic               w_pop_ok;
   logic               w_alloc;
   logic [LABEL_W-1:0] w_lo;
   logic [LABEL_W-1:0] w_hi;
   logic [PAIR_W-1:0]  w_pop_pair;
   logic               w_we;
   logic [LABEL_W-1:0] w_waddr;
   logic [LABEL_W-1:0] w_wdata;
   logic [1:0]         w_push;
   logic [1:0]         w_pop;
   logic [1:0]         w_full;
   logic [1:0]         w_empty;
   logic [PAIR_W-1:0]  w_top [2];
   logic               w_stack_clear;

   assign w_run     = (r_state == ST_RUN);
   assign w_restart = en && frame_start;
   assign busy      = (r_state == ST_CLEAR);
   assign stacks_empty  = &w_empty;
   assign w_stack_clear = reset || w_restart;

   assign w_lo = (merge_a < merge_b) ? merge_a : merge_b;
   assign w_hi = (merge_a < merge_b) ? merge_b : merge_a;

   assign w_merge_ok = w_run && en && !frame_start && merge_push &&
                       (merge_a != merge_b) && (merge_a != BG) && (merge_b != BG);
   // A label allocation owns the table write port, so draining yields to it.
   assign w_pop_ok   = w_run && en && !frame_start && !new_label_req &&
                       (row_sel ? !w_empty[0] : !w_empty[1]);
   assign w_alloc    = w_run && en && !frame_start && new_label_req &&
                       (num_labels != LAST_LABEL);
   assign w_pop_pair = row_sel ? w_top[0] : w_top[1];

   for (genvar s = 0; s < 2; s++) begin : g_stack
      assign w_push[s] = w_merge_ok && (row_sel == 1'(s));
      assign w_pop[s]  = w_pop_ok && (row_sel != 1'(s));

      merge_stack #(
         .DEPTH  (STACK_DEPTH),
         .DATA_W (PAIR_W)
      ) u_stack (
         .clk       (clk),
         .clear     (w_stack_clear),
         .push      (w_push[s]),
         .pop       (w_pop[s]),
         .push_data ({w_hi, w_lo}),
         .top_data  (w_top[s]),
         .full      (w_full[s]),
         .empty     (w_empty[s])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_CLEAR;
         r_cnt      <= '0;
         num_labels <= LABEL_W'(1);
         overflow   <= 1'b0;
         exhausted  <= 1'b0;
      end else if (en) begin
         if (frame_start) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            num_labels <= LABEL_W'(1);
            overflow   <= 1'b0;
            exhausted  <= 1'b0;
         end else if (r_state == ST_CLEAR) begin
            r_cnt <= r_cnt + LABEL_W'(1);
            if (r_cnt == LAST_LABEL) begin
               r_state <= ST_RUN;
            end
         end else begin
            if (new_label_req) begin
               if (num_labels != LAST_LABEL) begin
                  num_labels <= num_labels + LABEL_W'(1);
               end else begin
                  exhausted <= 1'b1;
               end
            end
            if (w_merge_ok && (row_sel ? w_full[1] : w_full[0])) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // Allocation and pop results land in the table one enabled cycle later.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pend      <= 1'b0;
         r_pend_addr <= '0;
         r_pend_data <= '0;
      end else if (en) begin
         if (w_alloc) begin
            r_pend      <= 1'b1;
            r_pend_addr <= num_labels;
            r_pend_data <= num_labels;
         end else if (w_pop_ok) begin
            r_pend      <= 1'b1;
            r_pend_addr <= w_pop_pair[PAIR_W-1:LABEL_W];
            r_pend_data <= w_pop_pair[LABEL_W-1:0];
         end else begin
            r_pend      <= 1'b0;
         end
      end
   end

   assign w_we    = en && (busy || r_pend);
   assign w_waddr = busy ? r_cnt : r_pend_addr;
   assign w_wdata = busy ? r_cnt : r_pend_data;

   always_ff @(posedge clk) begin
      if (w_we) begin
         r_tbl[w_waddr] <= w_wdata;
      end
      r_rd <= r_tbl[lookup_addr];
   end

   assign lookup_data = busy ? '0 : r_rd;

endmodule

`default_nettype wire

// File: tb/tb_label_merge_unit.sv
// tb_label_merge_unit -- directed, table-driven bench for label_merge_unit.
// Revision 1.0
`default_nettype none

module tb_label_merge_unit;

   logic       clk = 1'b0;
   logic       reset, en, frame_start, row_sel, new_label_req, merge_push;
   logic [7:0] merge_a, merge_b, lookup_addr;
   logic [7:0] lookup_data, num_labels;
   logic       busy, stacks_empty, overflow, exhausted;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   label_merge_unit #(
      .LABEL_W     (8),
      .STACK_DEPTH (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .frame_start   (frame_start),
      .row_sel       (row_sel),
      .new_label_req (new_label_req),
      .merge_push    (merge_push),
      .merge_a       (merge_a),
      .merge_b       (merge_b),
      .lookup_addr   (lookup_addr),
      .lookup_data   (lookup_data),
      .num_labels    (num_labels),
      .busy          (busy),
      .stacks_empty  (stacks_empty),
      .overflow      (overflow),
      .exhausted     (exhausted)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       valid;
      logic [7:0] addr;
      logic [7:0] data;
   } mvec_t;

   mvec_t mv [5];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic look(input logic [7:0] a, input int exp);
      lookup_addr = a;
      tick();
      chk($sformatf("lookup[%0d]", a), 32'(lookup_data), exp);
   endtask

   task automatic merge1(input logic [7:0] a, input logic [7:0] b);
      merge_a    = a;
      merge_b    = b;
      merge_push = 1'b1;
      tick();
      merge_push = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      mv[0] = '{a: 8'd5,  b: 8'd3,  valid: 1'b1, addr: 8'd5,  data: 8'd3};
      mv[1] = '{a: 8'd10, b: 8'd20, valid: 1'b1, addr: 8'd20, data: 8'd10};
      mv[2] = '{a: 8'd4,  b: 8'd4,  valid: 1'b0, addr: 8'd4,  data: 8'd4};
      mv[3] = '{a: 8'd0,  b: 8'd7,  valid: 1'b0, addr: 8'd7,  data: 8'd7};
      mv[4] = '{a: 8'd9,  b: 8'd0,  valid: 1'b0, addr: 8'd9,  data: 8'd9};

      reset = 1'b1; en = 1'b1; frame_start = 1'b0; row_sel = 1'b0;
      new_label_req = 1'b0; merge_push = 1'b0;
      merge_a = '0; merge_b = '0; lookup_addr = '0;
      repeat (3) tick();

      chk("rst_busy", 32'(busy), 1);
      chk("rst_num", 32'(num_labels), 1);
      chk("rst_empty", 32'(stacks_empty), 1);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_exh", 32'(exhausted), 0);
      chk("rst_lookup", 32'(lookup_data), 0);

      reset = 1'b0;
      n = 0;
      while (busy && n < 1000) begin
         n++;
         tick();
      end
      chk("clear_len", n, 256);
      for (int i = 0; i < 256; i++) look(8'(i), i);

      new_label_req = 1'b1;
      repeat (3) tick();
      new_label_req = 1'b0;
      chk("alloc_num", 32'(num_labels), 4);
      tick();
      for (int i = 1; i <= 3; i++) look(8'(i), i);

      en = 1'b0; new_label_req = 1'b1;
      tick();
      chk("en_hold_num", 32'(num_labels), 4);
      en = 1'b1; new_label_req = 1'b0;

      for (int i = 0; i < 5; i++) begin
         row_sel = 1'b0;
         merge1(mv[i].a, mv[i].b);
         chk($sformatf("vec%0d_pushed", i), 32'(stacks_empty), mv[i].valid ? 0 : 1);
         row_sel = 1'b1;
         repeat (2) tick();
         chk($sformatf("vec%0d_drained", i), 32'(stacks_empty), 1);
         look(mv[i].addr, 32'(mv[i].data));
      end

      // pop edge, then write edge; lookup sees old data until the write lands
      row_sel = 1'b0;
      merge1(8'd6, 8'd2);
      chk("seq_push", 32'(stacks_empty), 0);
      row_sel = 1'b1; lookup_addr = 8'd6;
      tick();
      chk("seq_pop", 32'(stacks_empty), 1);
      chk("seq_old0", 32'(lookup_data), 6);
      tick();
      chk("seq_old1", 32'(lookup_data), 6);
      tick();
      chk("seq_new", 32'(lookup_data), 2);

      row_sel = 1'b0;
      merge1(8'd30, 8'd31);
      row_sel = 1'b1; new_label_req = 1'b1;
      tick();
      new_label_req = 1'b0;
      chk("suppress_empty", 32'(stacks_empty), 0);
      chk("suppress_num", 32'(num_labels), 5);
      tick();
      chk("suppress_drain", 32'(stacks_empty), 1);
      tick();
      look(8'd31, 30);

      row_sel = 1'b0;
      merge1(8'd11, 8'd12);
      merge1(8'd14, 8'd13);
      merge1(8'd15, 8'd16);
      merge1(8'd17, 8'd18);
      chk("ovf_before", 32'(overflow), 0);
      merge1(8'd19, 8'd21);
      chk("ovf_after", 32'(overflow), 1);
      row_sel = 1'b1;
      repeat (5) tick();
      chk("ovf_drained", 32'(stacks_empty), 1);
      chk("ovf_sticky", 32'(overflow), 1);
      look(8'd12, 11);
      look(8'd14, 13);
      look(8'd16, 15);
      look(8'd18, 17);
      look(8'd21, 21);

      row_sel = 1'b0;
      merge1(8'd200, 8'd255);
      row_sel = 1'b1;
      repeat (2) tick();
      new_label_req = 1'b1;
      repeat (250) tick();
      chk("exh_num_255", 32'(num_labels), 255);
      chk("exh_not_yet", 32'(exhausted), 0);
      tick();
      chk("exh_set", 32'(exhausted), 1);
      chk("exh_num_hold", 32'(num_labels), 255);
      new_label_req = 1'b0;
      tick();
      chk("exh_sticky", 32'(exhausted), 1);
      tick();
      look(8'd254, 254);
      look(8'd255, 200);

      row_sel = 1'b0;
      merge1(8'd40, 8'd41);
      merge1(8'd42, 8'd43);
      merge1(8'd44, 8'd45);
      merge1(8'd46, 8'd47);
      merge1(8'd48, 8'd49);
      chk("fs_ovf_pre", 32'(overflow), 1);
      row_sel = 1'b1; lookup_addr = 8'd41;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      chk("fs_empty", 32'(stacks_empty), 1);
      chk("fs_num", 32'(num_labels), 1);
      chk("fs_ovf", 32'(overflow), 0);
      chk("fs_exh", 32'(exhausted), 0);
      chk("fs_busy", 32'(busy), 1);
      chk("fs_lookup0", 32'(lookup_data), 0);
      n = 0;
      while (busy && n < 1000) begin
         if (n == 10) begin
            new_label_req = 1'b1;
            merge_a = 8'd50; merge_b = 8'd60; merge_push = 1'b1;
         end
         if (n == 20) begin
            new_label_req = 1'b0;
            merge_push = 1'b0;
         end
         if (n == 100) chk("fs_busy_lookup", 32'(lookup_data), 0);
         n++;
         tick();
      end
      chk("fs_clear_len", n, 256);
      chk("fs_ignored_num", 32'(num_labels), 1);
      chk("fs_ignored_push", 32'(stacks_empty), 1);
      look(8'd41, 41);
      look(8'd200, 200);
      look(8'd255, 255);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
